job_rd_arbiter: RTL and testbench

- Shares the single AXI read master between REQ_NUM job_manager instances, one per kernel, so several kernels can fetch job descriptors concurrently.
- Round-robin arbitration on AR; each granted burst is tagged with the requester index as ARID.
- Returning R beats are steered to the requester named by RID.
- Caps in-flight bursts at MAX_OUT.

---
 rtl/job_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_job_rd_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/job_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read master among REQ_NUM job managers.
// AR bursts are tagged with the requester index; R beats are steered back by RID.
module job_rd_arbiter #(
  parameter int REQ_NUM    = 8,
  parameter int M_ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_OUT    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_NUM-1:0]            s_arvalid,
  output logic [REQ_NUM-1:0]            s_arready,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] s_araddr,
  input  logic [REQ_NUM*8-1:0]          s_arlen,
  output logic [REQ_NUM-1:0]            s_rvalid,
  input  logic [REQ_NUM-1:0]            s_rready,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic [M_ID_WIDTH-1:0]         m_axi_arid,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic [3:0]                    m_axi_arcache,
  output logic                          m_axi_arlock,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic [3:0]                    m_axi_arregion,
  output logic                          m_axi_aruser,
  input  logic [M_ID_WIDTH-1:0]         m_axi_rid,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [3:0]                    outstanding,
  output logic                          stray_err
);

  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic {IDLE, ADDR} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] cand;
  logic             any_req;
  logic             grant;
  logic             rid_ok;
  logic             rsel;
  logic             rlast_hs;
  logic             dec;

  assign m_axi_arsize   = 3'd6;
  assign m_axi_arburst  = 2'd1;
  assign m_axi_arcache  = 4'd3;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_aruser   = 1'b0;

  assign s_rdata = m_axi_rdata;
  assign s_rresp = m_axi_rresp;
  assign s_rlast = m_axi_rlast;

  // Scan downward so the last hit is the closest valid requester at/after rr_ptr.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr) + k) % REQ_NUM);
      if (s_arvalid[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    s_arready  = '0;
    case (state)
      IDLE: begin
        if (any_req && (outstanding < 4'(MAX_OUT))) begin
          grant             = 1'b1;
          s_arready[winner] = 1'b1;
          state_next        = ADDR;
        end
      end
      ADDR: begin
        if (m_axi_arready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arid    <= '0;
      rr_ptr        <= '0;
    end else begin
      m_axi_arvalid <= (state_next == ADDR);
      if (grant) begin
        m_axi_araddr <= s_araddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_arlen  <= s_arlen[winner*8 +: 8];
        m_axi_arid   <= M_ID_WIDTH'(winner);
        rr_ptr       <= (winner == PTR_W'(REQ_NUM - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  // Beats carrying an ID with no requester behind it are sunk rather than stalling the bus.
  assign rid_ok = ({1'b0, m_axi_rid} < (M_ID_WIDTH + 1)'(REQ_NUM));

  always_comb begin
    s_rvalid = '0;
    rsel     = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (m_axi_rid == M_ID_WIDTH'(i)) begin
        s_rvalid[i] = m_axi_rvalid;
        rsel        = s_rready[i];
      end
    end
  end

  assign m_axi_rready = rid_ok ? rsel : 1'b1;
  assign rlast_hs     = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign dec          = rlast_hs && (outstanding != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 4'd0;
      stray_err   <= 1'b0;
    end else begin
      if (grant && !dec)      outstanding <= outstanding + 4'd1;
      else if (!grant && dec) outstanding <= outstanding - 4'd1;
      if (m_axi_rvalid && !rid_ok) stray_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_job_rd_arbiter.sv
// Scoreboard bench for job_rd_arbiter: expected grants/AR beats are queued as
// requests are driven and checked when the DUT grants or hands off on AR.
module tb_job_rd_arbiter;

  localparam int REQ_NUM    = 8;
  localparam int M_ID_WIDTH = 4;
  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 512;
  localparam int MAX_OUT    = 4;

  logic                          clk;
  logic                          rst;
  logic [REQ_NUM-1:0]            s_arvalid;
  logic [REQ_NUM-1:0]            s_arready;
  logic [REQ_NUM*ADDR_WIDTH-1:0] s_araddr;
  logic [REQ_NUM*8-1:0]          s_arlen;
  logic [REQ_NUM-1:0]            s_rvalid;
  logic [REQ_NUM-1:0]            s_rready;
  logic [DATA_WIDTH-1:0]         s_rdata;
  logic [1:0]                    s_rresp;
  logic                          s_rlast;
  logic [M_ID_WIDTH-1:0]         m_axi_arid;
  logic [ADDR_WIDTH-1:0]         m_axi_araddr;
  logic [7:0]                    m_axi_arlen;
  logic                          m_axi_arvalid;
  logic                          m_axi_arready;
  logic [2:0]                    m_axi_arsize;
  logic [1:0]                    m_axi_arburst;
  logic [3:0]                    m_axi_arcache;
  logic                          m_axi_arlock;
  logic [2:0]                    m_axi_arprot;
  logic [3:0]                    m_axi_arqos;
  logic [3:0]                    m_axi_arregion;
  logic                          m_axi_aruser;
  logic [M_ID_WIDTH-1:0]         m_axi_rid;
  logic [DATA_WIDTH-1:0]         m_axi_rdata;
  logic [1:0]                    m_axi_rresp;
  logic                          m_axi_rlast;
  logic                          m_axi_rvalid;
  logic                          m_axi_rready;
  logic [3:0]                    outstanding;
  logic                          stray_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  int                                     grant_q[$];
  logic [M_ID_WIDTH+ADDR_WIDTH+8-1:0]     ar_q[$];
  logic [REQ_NUM-1:0]                     gnt_seen;
  logic [REQ_NUM-1:0]                     drop_mask;
  int                                     exp_g;
  logic [M_ID_WIDTH+ADDR_WIDTH+8-1:0]     exp_ar;

  job_rd_arbiter #(
    .REQ_NUM(REQ_NUM), .M_ID_WIDTH(M_ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
    .m_axi_arlock(m_axi_arlock), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .outstanding(outstanding), .stray_err(stray_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] beatData(input int b);
    return {16{32'hC0DE0000 + 32'(b)}};
  endfunction

  // Grant pulses and AR handshakes are consumed mid-cycle against the scoreboard.
  always @(negedge clk) begin
    gnt_seen = s_arready;
    if (s_arready != '0) begin
      if (grant_q.size() == 0) checkOutput("unexpected_grant", s_arready, 0);
      else begin
        exp_g = grant_q.pop_front();
        checkOutput("grant", s_arready, REQ_NUM'(1) << exp_g);
      end
    end
    if (m_axi_arvalid && m_axi_arready) begin
      if (ar_q.size() == 0) checkOutput("unexpected_ar", m_axi_arvalid, 0);
      else begin
        exp_ar = ar_q.pop_front();
        checkOutput("ar_beat", {m_axi_arid, m_axi_araddr, m_axi_arlen}, exp_ar);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    s_arvalid = s_arvalid & ~(gnt_seen & drop_mask);
  endtask

  task automatic applyStimulus(input int idx, input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                               input bit expect_ar);
    s_arvalid[idx]                       = 1'b1;
    s_araddr[idx*ADDR_WIDTH +: ADDR_WIDTH] = addr;
    s_arlen[idx*8 +: 8]                  = len;
    grant_q.push_back(idx);
    if (expect_ar) ar_q.push_back({M_ID_WIDTH'(idx), addr, len});
  endtask

  task automatic expectAgain(input int idx, input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len);
    grant_q.push_back(idx);
    ar_q.push_back({M_ID_WIDTH'(idx), addr, len});
  endtask

  task automatic waitDrain(input string tag, input int budget);
    for (int c = 0; c < budget && (grant_q.size() != 0 || ar_q.size() != 0); c++) tick();
    checkOutput(tag, grant_q.size() + ar_q.size(), 0);
  endtask

  task automatic resetDut();
    rst           = 1'b1;
    s_arvalid     = '0;
    s_araddr      = '0;
    s_arlen       = '0;
    s_rready      = '1;
    m_axi_arready = 1'b0;
    m_axi_rid     = '0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'd0;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
    drop_mask     = '1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic sendBeat(input int rid, input int b, input bit last);
    m_axi_rid    = M_ID_WIDTH'(rid);
    m_axi_rdata  = beatData(b);
    m_axi_rlast  = last;
    m_axi_rvalid = 1'b1;
  endtask

  task automatic idleBeat();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  initial begin
    int  b;
    bit  pat;
    gnt_seen = '0;
    resetDut();

    checkOutput("rst_arvalid", m_axi_arvalid, 0);
    checkOutput("rst_araddr", m_axi_araddr, 0);
    checkOutput("rst_arlen", m_axi_arlen, 0);
    checkOutput("rst_arid", m_axi_arid, 0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_stray", stray_err, 0);
    checkOutput("const_ar", {m_axi_arsize, m_axi_arburst, m_axi_arcache},
                {3'd6, 2'd1, 4'd3});

    // Single request from requester 2
    applyStimulus(2, 64'h1000, 8'd0, 1);
    #1 checkOutput("t1_arready", s_arready, 8'h04);
    tick();
    checkOutput("t1_arready_pulse", s_arready, 0);
    checkOutput("t1_arvalid", m_axi_arvalid, 1);
    checkOutput("t1_arid", m_axi_arid, 2);
    checkOutput("t1_araddr", m_axi_araddr, 64'h1000);
    checkOutput("t1_out1", outstanding, 1);
    tick();
    checkOutput("t1_arvalid_hold", m_axi_arvalid, 1);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    checkOutput("t1_arvalid_drop", m_axi_arvalid, 0);
    sendBeat(2, 0, 1);
    #1;
    checkOutput("t1_rvalid", s_rvalid, 8'h04);
    checkOutput("t1_rready", m_axi_rready, 1);
    checkOutput("t1_rdata", s_rdata, beatData(0));
    tick();
    idleBeat();
    checkOutput("t1_out0", outstanding, 0);

    // Contention among 0, 3, 7; requester 0 keeps asking
    resetDut();
    m_axi_arready = 1'b1;
    drop_mask     = 8'hFE;
    applyStimulus(0, 64'h100, 8'd1, 1);
    applyStimulus(3, 64'h300, 8'd2, 1);
    applyStimulus(7, 64'h700, 8'd3, 1);
    expectAgain(0, 64'h100, 8'd1);
    waitDrain("t2_drain", 30);
    s_arvalid = '0;
    drop_mask = '1;
    checkOutput("t2_out", outstanding, 4);

    // Outstanding cap with all eight requesters valid
    resetDut();
    m_axi_arready = 1'b1;
    for (int i = 0; i < REQ_NUM; i++)
      applyStimulus(i, 64'h8000 + 64'(i * 64), 8'(i), i < MAX_OUT);
    for (int i = MAX_OUT; i < REQ_NUM; i++) void'(grant_q.pop_back());
    waitDrain("t3_drain", 30);
    repeat (4) tick();
    checkOutput("t3_out_cap", outstanding, 4);
    checkOutput("t3_no_grant", s_arready, 0);
    expectAgain(4, 64'h8000 + 64'(4 * 64), 8'd4);
    sendBeat(1, 9, 1);
    #1 checkOutput("t3_rready", m_axi_rready, 1);
    tick();
    idleBeat();
    waitDrain("t3_extra", 10);
    repeat (4) tick();
    checkOutput("t3_out_cap2", outstanding, 4);
    s_arvalid = '0;

    // R backpressure on requester 5
    b = 0;
    for (int c = 0; c < 20 && b < 4; c++) begin
      pat         = c[0];
      s_rready    = '1;
      s_rready[5] = pat;
      sendBeat(5, b, b == 3);
      #1;
      checkOutput("t4_rready", m_axi_rready, pat);
      checkOutput("t4_rvalid", s_rvalid, 8'h20);
      checkOutput("t4_rdata", s_rdata, beatData(b));
      if (pat) b++;
      tick();
    end
    idleBeat();
    s_rready = '1;
    checkOutput("t4_beats", b, 4);
    checkOutput("t4_out", outstanding, 3);

    // Grant and rlast in the same cycle
    applyStimulus(6, 64'h600, 8'd5, 1);
    sendBeat(5, 1, 1);
    #1;
    checkOutput("t5_arready", s_arready, 8'h40);
    checkOutput("t5_rready", m_axi_rready, 1);
    tick();
    idleBeat();
    checkOutput("t5_out_same", outstanding, 3);
    waitDrain("t5_drain", 10);

    // Stray RID is sunk and flagged
    s_rready = '0;
    sendBeat(12, 2, 1);
    #1;
    checkOutput("t5_stray_rready", m_axi_rready, 1);
    checkOutput("t5_stray_rvalid", s_rvalid, 0);
    checkOutput("t5_stray_pre", stray_err, 0);
    tick();
    idleBeat();
    s_rready = '1;
    checkOutput("t5_stray_set", stray_err, 1);
    checkOutput("t5_stray_out", outstanding, 2);
    tick();
    checkOutput("t5_stray_sticky", stray_err, 1);

    // Async reset while AR is pending
    m_axi_arready = 1'b0;
    applyStimulus(3, 64'h3000, 8'd7, 0);
    tick();
    checkOutput("t6_arvalid", m_axi_arvalid, 1);
    checkOutput("t6_arid", m_axi_arid, 3);
    #2;
    rst       = 1'b1;
    s_arvalid = '0;
    #1;
    checkOutput("t6_arvalid_rst", m_axi_arvalid, 0);
    checkOutput("t6_out_rst", outstanding, 0);
    checkOutput("t6_stray_rst", stray_err, 0);
    tick();
    rst = 1'b0;
    tick();
    m_axi_arready = 1'b1;
    applyStimulus(0, 64'h0, 8'd2, 1);
    applyStimulus(5, 64'h5000, 8'd1, 1);
    void'(grant_q.pop_back());
    void'(ar_q.pop_back());
    void'(grant_q.pop_back());
    void'(ar_q.pop_back());
    expectAgain(0, 64'h0, 8'd2);
    expectAgain(5, 64'h5000, 8'd1);
    waitDrain("t6_drain", 20);
    checkOutput("t6_out_final", outstanding, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
